// File: rtl/hash_jtree_elastic_pkg.sv
// Shared definitions for the jittered sample pipeline: hash widths and
// MSAA mode decoding.
package hash_jtree_elastic_pkg;

    // Widest jitter mask the decoder can describe; callers truncate to HASH_OUT.
    localparam int MASK_MAX = 32;

    // Result of decoding an MSAA mode: the jitter mask plus a flag for
    // a non-one-hot mode.
    typedef struct packed {
        logic                err;
        logic [MASK_MAX-1:0] mask;
    } mask_res_t;

    // Jitter field width: fractional bits minus the two guard bits.
    function automatic int hash_out_w(input int radix);
        return radix - 2;
    endfunction

    // Hash input is the integer-ish part (bits above 3) of both coordinates.
    function automatic int hash_in_w(input int sigfig);
        return 2 * (sigfig - 4);
    endfunction

    // Finer MSAA modes get a narrower jitter range; anything that is not
    // one-hot gets no jitter at all and raises the error flag.
    function automatic mask_res_t msaa_mask(input logic [3:0] sub, input int width);
        mask_res_t           r;
        logic [MASK_MAX-1:0] ones;
        ones   = (width >= MASK_MAX) ? '1 : ((MASK_MAX'(1) << width) - MASK_MAX'(1));
        r.err  = 1'b0;
        r.mask = '0;
        case (sub)
            4'b1000: r.mask = ones;
            4'b0100: r.mask = ones >> 1;
            4'b0010: r.mask = ones >> 2;
            4'b0001: r.mask = ones >> 3;
            default: r.err  = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hash_jtree_elastic_stage.sv
// Single-entry valid/ready register. Ready is combinational from the
// downstream ready so a chain of these has no bubbles.
module elastic_stage #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    // Load when empty or when the current entry leaves this cycle.
    always_comb begin
        ready_o = !valid_q || ready_i;
        load    = valid_i && ready_o;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry register; data is only rewritten on a load so it holds when idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/tree_hash.sv
// Position hash leaf: splits the input into OUT_W-bit chunks, rotates
// chunk c left by c and XORs all chunks together.
module tree_hash #(
    parameter int IN_W  = 40,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  data_i,
    output logic [OUT_W-1:0] hash_o
);

    localparam int NCHUNK = (IN_W + OUT_W - 1) / OUT_W;

    logic [NCHUNK*OUT_W-1:0] padded;
    logic [OUT_W-1:0]        chunk;
    logic [OUT_W-1:0]        acc;

    // Zero-pad the input, then fold rotated chunks into one word.
    always_comb begin
        padded                = '0;
        padded[IN_W-1:0]      = data_i;
        acc                   = '0;
        chunk                 = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            chunk = padded[c*OUT_W +: OUT_W];
            acc   = acc ^ ((chunk << (c % OUT_W)) | (chunk >> (OUT_W - (c % OUT_W))));
        end
        hash_o = acc;
    end

endmodule

// File: rtl/hash_jtree_elastic.sv
// Raster jitter stage: hashes each sample position, masks the hash by the
// MSAA mode, ORs it into the fractional bits, and carries the result through
// an elastic valid/ready pipeline of PIPE_DEPTH stages.
module hash_jtree_elastic
    import hash_jtree_elastic_pkg::*;
#(
    parameter int SIGFIG     = 24,
    parameter int RADIX      = 10,
    parameter int VERTS      = 3,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int SAMPS      = 4,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in,
    input  logic [COLORS-1:0][SIGFIG-1:0]               color_in,
    input  logic signed [1:0][SAMPS-1:0][SIGFIG-1:0]    sample_in,
    input  logic [SAMPS-1:0]                            validSamp_in,
    input  logic [3:0]                                  subSample,
    input  logic                                        jitter_en,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_out,
    output logic [COLORS-1:0][SIGFIG-1:0]               color_out,
    output logic signed [1:0][SAMPS-1:0][SIGFIG-1:0]    sample_out,
    output logic [SAMPS-1:0]                            validSamp_out,
    output logic                                        cfg_err
);

    localparam int HASH_OUT = hash_out_w(RADIX);
    localparam int HASH_IN  = hash_in_w(SIGFIG);

    typedef struct packed {
        logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] triV;
        logic [COLORS-1:0][SIGFIG-1:0]          colorV;
        logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sampleV;
        logic [SAMPS-1:0]                       validV;
    } payload_t;

    localparam int PW = $bits(payload_t);

    mask_res_t                        mres;
    logic [MASK_MAX-1:0]              maskWide;
    logic [SAMPS-1:0][HASH_OUT-1:0]   hashX, hashY;
    logic [1:0][SAMPS-1:0][SIGFIG-1:0] jitSample;
    payload_t                         inPayload, outPayload;
    logic                             cfgErr_q, cfgErr_d;

    logic [PIPE_DEPTH:0]              stgValid, stgReady;
    logic [PIPE_DEPTH:0][PW-1:0]      stgData;

    assign mres     = msaa_mask(subSample, HASH_OUT);
    assign maskWide = mres.mask;

    // x jitter hashes (y,x), y jitter hashes (x,y) so the two axes differ.
    for (genvar i = 0; i < SAMPS; i++) begin : g_lane
        tree_hash #(.IN_W(HASH_IN), .OUT_W(HASH_OUT)) uHashX (
            .data_i ({sample_in[1][i][SIGFIG-1:4], sample_in[0][i][SIGFIG-1:4]}),
            .hash_o (hashX[i])
        );
        tree_hash #(.IN_W(HASH_IN), .OUT_W(HASH_OUT)) uHashY (
            .data_i ({sample_in[0][i][SIGFIG-1:4], sample_in[1][i][SIGFIG-1:4]}),
            .hash_o (hashY[i])
        );
    end

    // OR the masked jitter into the fractional field only; no carries, and
    // invalid lanes are jittered too.
    always_comb begin
        jitSample = sample_in;
        if (jitter_en) begin
            for (int i = 0; i < SAMPS; i++) begin
                jitSample[0][i][RADIX-1:2] = sample_in[0][i][RADIX-1:2]
                                           | HASH_OUT'(MASK_MAX'(hashX[i]) & maskWide);
                jitSample[1][i][RADIX-1:2] = sample_in[1][i][RADIX-1:2]
                                           | HASH_OUT'(MASK_MAX'(hashY[i]) & maskWide);
            end
        end
    end

    // Pack everything that travels with the transaction.
    always_comb begin
        inPayload.triV    = tri_in;
        inPayload.colorV  = color_in;
        inPayload.sampleV = jitSample;
        inPayload.validV  = validSamp_in;
    end

    assign stgValid[0]          = in_valid;
    assign stgData[0]           = inPayload;
    assign stgReady[PIPE_DEPTH] = out_ready;
    assign in_ready             = stgReady[0];

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        elastic_stage #(.W(PW)) uStage (
            .clk_i   (clk),
            .rst_i   (rst),
            .valid_i (stgValid[k]),
            .ready_o (stgReady[k]),
            .data_i  (stgData[k]),
            .valid_o (stgValid[k+1]),
            .ready_i (stgReady[k+1]),
            .data_o  (stgData[k+1])
        );
    end

    assign outPayload    = stgData[PIPE_DEPTH];
    assign out_valid     = stgValid[PIPE_DEPTH];
    assign tri_out       = outPayload.triV;
    assign color_out     = outPayload.colorV;
    assign sample_out    = outPayload.sampleV;
    assign validSamp_out = outPayload.validV;

    // Sticky error: any accepted transaction with a bad MSAA mode.
    always_comb begin
        cfgErr_d = cfgErr_q | (in_valid && in_ready && mres.err);
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfgErr_q <= 1'b0;
        end else begin
            cfgErr_q <= cfgErr_d;
        end
    end

    assign cfg_err = cfgErr_q;

    aValidKnown : assert property (@(posedge clk) disable iff (rst) !$isunknown(in_valid));

    aOutStable : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> $stable(outPayload));

endmodule

// File: tb/tb_hash_jtree_elastic.sv
// Directed bench for hash_jtree_elastic at default parameters
// (SIGFIG=24, RADIX=10, SAMPS=4, PIPE_DEPTH=2).
module tb_hash_jtree_elastic;

    typedef logic [1:0][3:0][23:0] samp_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, jitter_en, cfg_err;
    logic signed [2:0][2:0][23:0] tri_in, tri_out;
    logic [2:0][23:0]             color_in, color_out;
    logic signed [1:0][3:0][23:0] sample_in, sample_out;
    logic [3:0]                   validSamp_in, validSamp_out, subSample;

    int    nChecks = 0;
    int    nPass   = 0;
    logic  accSeen, xferSeen;
    samp_t outSnap;
    samp_t expQ[$];

    logic [3:0]  subs  [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [23:0] xHand [4] = '{24'h00148F, 24'h00148F, 24'h00148F, 24'h00140F};
    logic [23:0] yHand [4] = '{24'h002D90, 24'h002D90, 24'h002C90, 24'h002C10};

    hash_jtree_elastic dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .tri_in(tri_in), .color_in(color_in), .sample_in(sample_in),
        .validSamp_in(validSamp_in), .subSample(subSample), .jitter_en(jitter_en),
        .out_valid(out_valid), .out_ready(out_ready), .tri_out(tri_out),
        .color_out(color_out), .sample_out(sample_out),
        .validSamp_out(validSamp_out), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Reference hash: input bit i lands on output bit (i%8 + i/8) % 8.
    function automatic logic [7:0] ref_hash(input logic [39:0] d);
        logic [7:0] h = '0;
        for (int i = 0; i < 40; i++) h[(i % 8 + i / 8) % 8] = h[(i % 8 + i / 8) % 8] ^ d[i];
        return h;
    endfunction

    function automatic logic [7:0] ref_mask(input logic [3:0] s);
        case (s)
            4'b1000: return 8'hFF;
            4'b0100: return 8'h7F;
            4'b0010: return 8'h3F;
            4'b0001: return 8'h1F;
            default: return 8'h00;
        endcase
    endfunction

    function automatic samp_t ref_jitter(input samp_t s, input logic [3:0] sub, input logic jit);
        samp_t      r = s;
        logic [7:0] m, jx, jy;
        m = ref_mask(sub);
        if (jit) begin
            for (int i = 0; i < 4; i++) begin
                jx = ref_hash({s[1][i][23:4], s[0][i][23:4]}) & m;
                jy = ref_hash({s[0][i][23:4], s[1][i][23:4]}) & m;
                r[0][i] = s[0][i] | {14'd0, jx, 2'd0};
                r[1][i] = s[1][i] | {14'd0, jy, 2'd0};
            end
        end
        return r;
    endfunction

    // Deterministic transaction contents derived from an index.
    task automatic drive_tx(input int k);
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                tri_in[v][a] = 24'(k * 4096 + v * 16 + a + 1);
        for (int c = 0; c < 3; c++) color_in[c] = 24'(k * 256 + c + 32'hA00000);
        for (int i = 0; i < 4; i++) begin
            sample_in[0][i] = 24'(k * 32'h00013579 + i * 32'h00111117);
            sample_in[1][i] = 24'(k * 32'h0002468B + i * 32'h00F0F0F3 + 7);
        end
        validSamp_in = 4'(k + 5);
    endtask

    // One clock: record handshakes and output data just before the edge.
    task automatic tick();
        @(negedge clk);
        accSeen  = in_valid && in_ready;
        xferSeen = out_valid && out_ready;
        outSnap  = sample_out;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; subSample = 4'b1000; jitter_en = 1'b1;
        drive_tx(0);
        tick(); tick();
        rst = 1'b0;
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else nPass++;
        nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else nPass++;
        nChecks++; if (cfg_err !== 1'b0) $display("[TB] FAIL reset_cfg_err got %b want 0", cfg_err); else nPass++;
        nChecks++; if (sample_out !== '0) $display("[TB] FAIL reset_sample_out got %h want 0", sample_out); else nPass++;
    endtask

    task automatic test_zeros();
        logic signed [2:0][2:0][23:0] triExp;
        logic [2:0][23:0]             colorExp;
        drive_tx(1);
        sample_in = '0; validSamp_in = 4'b1010; subSample = 4'b1000; jitter_en = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1;
        triExp = tri_in; colorExp = color_in;
        tick();
        in_valid = 1'b0;
        nChecks++; if (accSeen !== 1'b1) $display("[TB] FAIL zeros_accept got %b want 1", accSeen); else nPass++;
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL zeros_early got %b want 0", out_valid); else nPass++;
        tick();
        nChecks++; if (out_valid !== 1'b1) $display("[TB] FAIL zeros_latency got %b want 1", out_valid); else nPass++;
        nChecks++; if (sample_out !== '0) $display("[TB] FAIL zeros_sample got %h want 0", sample_out); else nPass++;
        nChecks++; if (tri_out !== triExp) $display("[TB] FAIL zeros_tri got %h want %h", tri_out, triExp); else nPass++;
        nChecks++; if (color_out !== colorExp) $display("[TB] FAIL zeros_color got %h want %h", color_out, colorExp); else nPass++;
        nChecks++; if (validSamp_out !== 4'b1010) $display("[TB] FAIL zeros_validSamp got %b want 1010", validSamp_out); else nPass++;
        tick();
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL zeros_drain got %b want 0", out_valid); else nPass++;
    endtask

    task automatic test_bypass();
        int    nAcc = 0, nOut = 0, run = 0, maxRun = 0;
        samp_t sent, want;
        expQ.delete();
        jitter_en = 1'b0; subSample = 4'b1000; out_ready = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc < 8) begin
                in_valid = 1'b1;
                drive_tx(10 + cyc);
                sample_in[0][0] = 24'h001400;
                sample_in[1][0] = 24'h002C00;
            end else begin
                in_valid = 1'b0;
            end
            sent = sample_in;
            tick();
            if (xferSeen) begin
                nOut++; run++;
                if (run > maxRun) maxRun = run;
                want = (expQ.size() > 0) ? expQ.pop_front() : '1;
                nChecks++; if (outSnap !== want) $display("[TB] FAIL bypass_data got %h want %h", outSnap, want); else nPass++;
            end else begin
                run = 0;
            end
            if (accSeen) begin
                expQ.push_back(sent);
                nAcc++;
            end
        end
        nChecks++; if (nAcc != 8) $display("[TB] FAIL bypass_accepts got %0d want 8", nAcc); else nPass++;
        nChecks++; if (nOut != 8) $display("[TB] FAIL bypass_outputs got %0d want 8", nOut); else nPass++;
        nChecks++; if (maxRun != 8) $display("[TB] FAIL bypass_consecutive got %0d want 8", maxRun); else nPass++;
    endtask

    task automatic test_mask_sweep();
        samp_t sent, want;
        logic  bad;
        jitter_en = 1'b1; out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            subSample = subs[m];
            drive_tx(40 + m);
            sample_in[0][0] = 24'h001403;
            sample_in[1][0] = 24'h002C00;
            sent = sample_in;
            want = ref_jitter(sent, subs[m], 1'b1);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            nChecks++; if (out_valid !== 1'b1) $display("[TB] FAIL mask%0d_valid got %b want 1", m, out_valid); else nPass++;
            nChecks++; if (sample_out[0][0] !== xHand[m]) $display("[TB] FAIL mask%0d_x0 got %h want %h", m, sample_out[0][0], xHand[m]); else nPass++;
            nChecks++; if (sample_out[1][0] !== yHand[m]) $display("[TB] FAIL mask%0d_y0 got %h want %h", m, sample_out[1][0], yHand[m]); else nPass++;
            nChecks++; if (sample_out !== want) $display("[TB] FAIL mask%0d_lanes got %h want %h", m, sample_out, want); else nPass++;
            bad = 1'b0;
            for (int a = 0; a < 2; a++)
                for (int i = 0; i < 4; i++)
                    if (((sample_out[a][i] ^ sent[a][i]) & 24'hFFFC03) != 24'h0) bad = 1'b1;
            nChecks++; if (bad !== 1'b0) $display("[TB] FAIL mask%0d_fixed_bits got %b want 0", m, bad); else nPass++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        int    nAcc = 0, nOut = 0;
        samp_t sent, want, held;
        expQ.delete();
        held = '0;
        jitter_en = 1'b1; subSample = 4'b0100; out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            drive_tx(60 + c);
            sent = sample_in;
            tick();
            if (accSeen) begin
                expQ.push_back(ref_jitter(sent, 4'b0100, 1'b1));
                nAcc++;
            end
            if (c == 3) held = sample_out;
        end
        nChecks++; if (nAcc != 2) $display("[TB] FAIL bp_accepts got %0d want 2", nAcc); else nPass++;
        nChecks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready got %b want 0", in_ready); else nPass++;
        nChecks++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_out_valid got %b want 1", out_valid); else nPass++;
        nChecks++; if (sample_out !== held) $display("[TB] FAIL bp_stall_stable got %h want %h", sample_out, held); else nPass++;
        out_ready = 1'b1;
        drive_tx(70);
        sent = sample_in;
        #1;
        nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_full_pass got %b want 1", in_ready); else nPass++;
        for (int c = 0; c < 7; c++) begin
            tick();
            in_valid = 1'b0;
            if (xferSeen) begin
                nOut++;
                want = (expQ.size() > 0) ? expQ.pop_front() : '1;
                nChecks++; if (outSnap !== want) $display("[TB] FAIL bp_order got %h want %h", outSnap, want); else nPass++;
            end
            if (accSeen) expQ.push_back(ref_jitter(sent, 4'b0100, 1'b1));
        end
        nChecks++; if (nOut != 3) $display("[TB] FAIL bp_outputs got %0d want 3", nOut); else nPass++;
        nChecks++; if (expQ.size() != 0) $display("[TB] FAIL bp_leftover got %0d want 0", expQ.size()); else nPass++;
    endtask

    task automatic test_config_midflight();
        int    nOut = 0;
        samp_t sent, want;
        expQ.delete();
        jitter_en = 1'b1; subSample = 4'b1000; out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            drive_tx(80 + c);
            sent = sample_in;
            tick();
            nChecks++; if (accSeen !== 1'b1) $display("[TB] FAIL cfg_accept%0d got %b want 1", c, accSeen); else nPass++;
            if (accSeen) expQ.push_back(ref_jitter(sent, 4'b1000, 1'b1));
        end
        in_valid = 1'b0;
        subSample = 4'b0001;
        tick(); tick();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (xferSeen) begin
                nOut++;
                want = (expQ.size() > 0) ? expQ.pop_front() : '1;
                nChecks++; if (outSnap !== want) $display("[TB] FAIL cfg_inflight got %h want %h", outSnap, want); else nPass++;
            end
        end
        nChecks++; if (nOut != 2) $display("[TB] FAIL cfg_inflight_count got %0d want 2", nOut); else nPass++;
        drive_tx(90);
        sample_in[0][0] = 24'h001403;
        sample_in[1][0] = 24'h002C00;
        sent = sample_in;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        nChecks++; if (sample_out[0][0] !== 24'h00140F) $display("[TB] FAIL cfg_new_x0 got %h want 00140f", sample_out[0][0]); else nPass++;
        nChecks++; if (sample_out[1][0] !== 24'h002C10) $display("[TB] FAIL cfg_new_y0 got %h want 002c10", sample_out[1][0]); else nPass++;
        want = ref_jitter(sent, 4'b0001, 1'b1);
        nChecks++; if (sample_out !== want) $display("[TB] FAIL cfg_new_lanes got %h want %h", sample_out, want); else nPass++;
        nChecks++; if (cfg_err !== 1'b0) $display("[TB] FAIL cfg_err_clean got %b want 0", cfg_err); else nPass++;
        tick();
        subSample = 4'b0110;
        drive_tx(91);
        sent = sample_in;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        nChecks++; if (cfg_err !== 1'b1) $display("[TB] FAIL cfg_err_set got %b want 1", cfg_err); else nPass++;
        tick();
        nChecks++; if (sample_out !== sent) $display("[TB] FAIL cfg_zero_mask got %h want %h", sample_out, sent); else nPass++;
        subSample = 4'b1000;
        drive_tx(92);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        nChecks++; if (cfg_err !== 1'b1) $display("[TB] FAIL cfg_err_sticky got %b want 1", cfg_err); else nPass++;
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        out_ready = 1'b0; subSample = 4'b1000; jitter_en = 1'b1;
        in_valid = 1'b1;
        drive_tx(100);
        tick();
        drive_tx(101);
        tick();
        in_valid = 1'b0;
        nChecks++; if (out_valid !== 1'b1) $display("[TB] FAIL rstmid_inflight got %b want 1", out_valid); else nPass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL rstmid_out_valid got %b want 0", out_valid); else nPass++;
        nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL rstmid_in_ready got %b want 1", in_ready); else nPass++;
        nChecks++; if (cfg_err !== 1'b0) $display("[TB] FAIL rstmid_cfg_err got %b want 0", cfg_err); else nPass++;
        nChecks++; if (sample_out !== '0) $display("[TB] FAIL rstmid_data got %h want 0", sample_out); else nPass++;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid !== 1'b0) stale++;
        end
        nChecks++; if (stale != 0) $display("[TB] FAIL rstmid_stale got %0d want 0", stale); else nPass++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; subSample = 4'b1000; jitter_en = 1'b1;
        tri_in = '0; color_in = '0; sample_in = '0; validSamp_in = '0;
        test_reset();
        test_zeros();
        test_bypass();
        test_mask_sweep();
        test_backpressure();
        test_config_midflight();
        test_reset_midstream();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
